// File: rtl/ext_mem_arb_pkg.sv
// ext_mem_arb_pkg: shared state encoding, grant codes and error read data for the external memory arbiter.
package ext_mem_arb_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DATA, ST_DONE} state_t;

   localparam logic [1:0] GNT_NONE  = 2'b00;
   localparam logic [1:0] GNT_FETCH = 2'b01;
   localparam logic [1:0] GNT_DATA  = 2'b10;

   localparam logic [7:0] RD_ERR_DATA = 8'hFF;

endpackage

// File: rtl/ext_mem_wait_cnt.sv
// ext_mem_wait_cnt: bus wait-state counter; expired_o flags the last allowed cycle before an abort.
module ext_mem_wait_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q;

   assign expired_o = cnt_q == CW'(TIMEOUT - 1);

   always_ff @(posedge clk or posedge rst)
      if (rst)
         cnt_q <= '0;
      else if (clr_i)
         cnt_q <= '0;
      else if (en_i && !expired_o)
         cnt_q <= cnt_q + 1'b1;

endmodule

// File: rtl/ext_mem_arbiter_8051.sv
// ext_mem_arbiter_8051: round-robin arbiter sharing one stb/ack memory bus between
// the instruction fetch and XRAM data requesters, with a hung-cycle timeout.
module ext_mem_arbiter_8051
   import ext_mem_arb_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int TIMEOUT   = 255,
   parameter int DATA_PRIO = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_adr,
   output logic          i_ack,
   output logic [DW-1:0] i_dat,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_adr,
   input  logic [DW-1:0] d_wdat,
   output logic          d_ack,
   output logic [DW-1:0] d_rdat,
   output logic          bus_stb,
   output logic          bus_we,
   output logic [AW-1:0] bus_adr,
   output logic [DW-1:0] bus_wdat,
   input  logic          bus_ack,
   input  logic [DW-1:0] bus_rdat,
   output logic          busy,
   output logic [1:0]    grant,
   output logic          timeout_err
);

   state_t        state_q, state_d;
   logic [1:0]    gnt_q, gnt_d, last_q, last_d;
   logic [AW-1:0] adr_q, adr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdat_q, wdat_d, dat_q, dat_d;
   logic          err_q, err_d;
   logic          active, expired, pick_data;

   assign active    = state_q == ST_FETCH || state_q == ST_DATA;
   // data wins when it is alone, or on a tie when fetch was served last
   assign pick_data = d_req && (!i_req || last_q == GNT_FETCH);

   ext_mem_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (!active),
      .en_i      (active && !bus_ack),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      adr_d   = adr_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      dat_d   = dat_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE:
            if (i_req || d_req) begin
               state_d = pick_data ? ST_DATA : ST_FETCH;
               gnt_d   = pick_data ? GNT_DATA : GNT_FETCH;
               adr_d   = pick_data ? d_adr : i_adr;
               we_d    = pick_data && d_we;
               wdat_d  = pick_data ? d_wdat : '0;
            end
         ST_FETCH, ST_DATA:
            if (bus_ack) begin
               state_d = ST_DONE;
               dat_d   = we_q ? '0 : bus_rdat;
            end else if (expired) begin
               state_d = ST_DONE;
               dat_d   = we_q ? '0 : DW'(RD_ERR_DATA);
               err_d   = 1'b1;
            end
         ST_DONE: begin
            state_d = ST_IDLE;
            last_d  = gnt_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= GNT_NONE;
         last_q  <= (DATA_PRIO != 0) ? GNT_FETCH : GNT_DATA;
         adr_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         dat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         wdat_q  <= wdat_d;
         dat_q   <= dat_d;
         err_q   <= err_d;
      end

   // outputs decode from state so an asynchronous reset drops them at once
   assign bus_stb     = active;
   assign bus_we      = active && we_q;
   assign bus_adr     = adr_q;
   assign bus_wdat    = wdat_q;
   assign busy        = state_q != ST_IDLE;
   assign grant       = busy ? gnt_q : GNT_NONE;
   assign i_ack       = state_q == ST_DONE && gnt_q == GNT_FETCH;
   assign d_ack       = state_q == ST_DONE && gnt_q == GNT_DATA;
   assign i_dat       = i_ack ? dat_q : '0;
   assign d_rdat      = d_ack ? dat_q : '0;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_ext_mem_arbiter_8051.sv
// tb_ext_mem_arbiter_8051: randomized bench with a transaction-level timing model of the arbiter.
module tb_ext_mem_arbiter_8051;
   import ext_mem_arb_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_adr = '0;
   logic          i_ack;
   logic [DW-1:0] i_dat;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_adr = '0;
   logic [DW-1:0] d_wdat = '0;
   logic          d_ack;
   logic [DW-1:0] d_rdat;
   logic          bus_stb, bus_we;
   logic [AW-1:0] bus_adr;
   logic [DW-1:0] bus_wdat;
   logic          bus_ack = 1'b0;
   logic [DW-1:0] bus_rdat = '0;
   logic          busy;
   logic [1:0]    grant;
   logic          timeout_err;

   always #5 clk = ~clk;

   ext_mem_arbiter_8051 #(.AW(AW), .DW(DW), .TIMEOUT(TO), .DATA_PRIO(1)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_dat(i_dat),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdat(d_wdat), .d_ack(d_ack), .d_rdat(d_rdat),
      .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdat(bus_wdat),
      .bus_ack(bus_ack), .bus_rdat(bus_rdat),
      .busy(busy), .grant(grant), .timeout_err(timeout_err)
   );

   int n_chk = 0, n_err = 0, cyc = 0, n_txn = 0;
   int start = 0, w = 0, ack_cyc = 0, free_cyc = 0, i_wait = 0, d_wait = 0;
   logic [1:0]    own = GNT_NONE, last = GNT_FETCH;
   logic          tmo = 1'b0, x_we = 1'b0, x_err = 1'b0;
   logic [AW-1:0] x_adr = '0;
   logic [DW-1:0] x_wdat = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int pick_wait();
      return ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, TO - 1));
   endfunction

   // model: a granted transaction starts in the cycle IDLE sees it, strobes w+1 cycles, acks one cycle later
   task automatic try_start();
      int wt;
      if (own == GNT_NONE && (i_req || d_req)) begin
         if (i_req && d_req)
            own = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
         else
            own = i_req ? GNT_FETCH : GNT_DATA;
         start  = (cyc < free_cyc) ? free_cyc : cyc;
         wt     = (own == GNT_DATA) ? d_wait : i_wait;
         tmo    = wt >= TO;
         w      = tmo ? TO - 1 : wt;
         ack_cyc = start + 2 + w;
         x_adr  = (own == GNT_DATA) ? d_adr : i_adr;
         x_we   = own == GNT_DATA && d_we;
         x_wdat = d_wdat;
      end
   endtask

   task automatic raise_i(input logic [AW-1:0] a, input int wt);
      i_req  = 1'b1;
      i_adr  = a;
      i_wait = wt;
   endtask

   task automatic raise_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int wt);
      d_req  = 1'b1;
      d_we   = we;
      d_adr  = a;
      d_wdat = wd;
      d_wait = wt;
   endtask

   task automatic step();
      logic ex_stb, ex_busy, ex_ack;
      logic [DW-1:0] ex_dat;
      int wt;
      @(negedge clk);
      cyc++;
      ex_stb  = own != GNT_NONE && cyc >= start + 1 && cyc <= start + 1 + w;
      ex_busy = own != GNT_NONE && cyc >= start + 1 && cyc <= ack_cyc;
      ex_ack  = own != GNT_NONE && cyc == ack_cyc;
      if (ex_ack && tmo) x_err = 1'b1;
      check("stb", bus_stb, ex_stb);
      check("busy", busy, ex_busy);
      check("grant", grant, ex_busy ? own : GNT_NONE);
      check("i_ack", i_ack, ex_ack && own == GNT_FETCH);
      check("d_ack", d_ack, ex_ack && own == GNT_DATA);
      check("timeout_err", timeout_err, x_err);
      if (ex_stb) begin
         check("bus_adr", bus_adr, x_adr);
         check("bus_we", bus_we, x_we);
         if (own == GNT_DATA) check("bus_wdat", bus_wdat, x_wdat);
      end
      ex_dat = x_we ? '0 : tmo ? 8'hFF : bus_rdat;
      if (ex_ack) check(own == GNT_FETCH ? "i_dat" : "d_rdat", own == GNT_FETCH ? i_dat : d_rdat, ex_dat);
      wt = (own == GNT_DATA) ? d_wait : i_wait;
      bus_ack  = (own != GNT_NONE && !tmo && cyc == start + 1 + wt) ? 1'b1 : (!ex_stb && $urandom_range(0, 3) == 0);
      bus_rdat = DW'($urandom);
      if (ex_busy && cyc > start && $urandom_range(0, 1) == 1) begin
         if (own == GNT_FETCH) i_adr = AW'($urandom);
         else begin
            d_adr  = AW'($urandom);
            d_we   = ~d_we;
            d_wdat = DW'($urandom);
         end
      end
      if (ex_ack) begin
         if (own == GNT_FETCH) i_req = 1'b0;
         else d_req = 1'b0;
         last = own;
         own = GNT_NONE;
         free_cyc = cyc + 1;
         n_txn++;
      end
      try_start();
   endtask

   task automatic drain();
      for (int g = 0; g < 40 && (own != GNT_NONE || i_req || d_req); g++) step();
      check("drain_idle", own, GNT_NONE);
   endtask

   initial begin
      #12;
      check("rst_stb", bus_stb, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, GNT_NONE);
      check("rst_acks", {i_ack, d_ack}, 0);
      check("rst_err", timeout_err, 0);
      check("rst_adr", bus_adr, 0);
      @(negedge clk);
      rst = 1'b0;
      // tie after reset with both requests held: data, fetch, data, fetch
      raise_i(16'h0010, 0);
      raise_d(1'b0, 16'h2000, 8'h00, 1);
      try_start();
      for (int g = 0; g < 60 && n_txn < 4; g++) begin
         step();
         if (!i_req && n_txn < 3) raise_i(AW'($urandom), 0);
         if (!d_req && n_txn < 3) raise_d(1'b0, AW'($urandom), 8'h00, 1);
         try_start();
      end
      check("tie_txns", n_txn, 4);
      drain();
      raise_i(16'h0100, 0);
      try_start();
      drain();
      raise_d(1'b1, 16'h8000, 8'h5A, 4);
      try_start();
      drain();
      raise_i(16'h0ABC, 99);
      try_start();
      drain();
      check("err_sticky", timeout_err, 1);
      for (int k = 0; k < 400; k++) begin
         step();
         if (!i_req && $urandom_range(0, 3) == 0) raise_i(AW'($urandom), pick_wait());
         if (!d_req && $urandom_range(0, 3) == 0)
            raise_d(1'($urandom), AW'($urandom), DW'($urandom), pick_wait());
         try_start();
      end
      drain();
      // asynchronous reset while a data cycle is strobing
      raise_d(1'b0, 16'h1234, 8'h00, 99);
      try_start();
      repeat (3) step();
      check("pre_rst_stb", bus_stb, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_stb", bus_stb, 0);
      check("arst_busy", busy, 0);
      check("arst_grant", grant, GNT_NONE);
      check("arst_err", timeout_err, 0);
      d_req = 1'b0;
      bus_ack = 1'b0;
      own = GNT_NONE;
      last = GNT_FETCH;
      x_err = 1'b0;
      repeat (3) begin
         @(negedge clk);
         cyc++;
         check("arst_d_ack", d_ack, 0);
      end
      rst = 1'b0;
      free_cyc = cyc;
      raise_i(16'h0055, 2);
      raise_d(1'b1, 16'h00AA, 8'h3C, 0);
      try_start();
      drain();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
